// File: rtl/sample_extend_pipe_if.sv
// Handshake bundle between the capture side and the datapath side of sample_extend_pipe.
// Producer signals are prefixed in_, consumer signals out_.
interface sample_extend_pipe_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    logic [IN_WIDTH-1:0]  in_data;
    logic [1:0]           in_mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_WIDTH-1:0] sample_count;

    modport master (
        output in_data, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sample_count
    );

    modport slave (
        input  in_data, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_valid, sample_count
    );
endinterface

// File: rtl/sample_extend_pipe.sv
// Width converter with per-sample extension mode, buffered in a 2-entry head/skid FIFO,
// plus a wrapping count of delivered words.
module sample_extend_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    sample_extend_pipe_if.slave bus
);
    localparam int E = OUT_WIDTH - IN_WIDTH;

    // Mode 00 zero, 01 sign, 10 offset-binary (MSB flip then sign), 11 left-justify.
    function automatic logic [OUT_WIDTH-1:0] extend(
        input logic [IN_WIDTH-1:0] d,
        input logic [1:0]          mode
    );
        logic signed [IN_WIDTH-1:0] s;
        logic [OUT_WIDTH-1:0]       r;
        s = $signed(d);
        r = OUT_WIDTH'(d);
        case (mode)
            2'b00: r = OUT_WIDTH'(d);
            2'b01: r = OUT_WIDTH'(s);
            2'b10: begin
                s[IN_WIDTH-1] = ~s[IN_WIDTH-1];
                r = OUT_WIDTH'(s);
            end
            default: r = OUT_WIDTH'(d) << E;
        endcase
        return r;
    endfunction

    logic [1:0]           count;
    logic [OUT_WIDTH-1:0] head_p0;
    logic [OUT_WIDTH-1:0] skid_p1;
    logic [CNT_WIDTH-1:0] sample_count;
    logic                 vld_p0;
    logic                 push;
    logic                 pop;
    logic [OUT_WIDTH-1:0] conv_word;

    assign vld_p0    = (count != 2'd0);
    assign conv_word = extend(bus.in_data, bus.in_mode);
    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = vld_p0 && bus.out_ready;

    // Ready depends only on registered occupancy so there is no path from out_ready.
    assign bus.in_ready     = (count != 2'd2) && !reset;
    assign bus.out_valid    = vld_p0;
    assign bus.out_data     = head_p0;
    assign bus.sample_count = sample_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= 2'd0;
            head_p0      <= '0;
            skid_p1      <= '0;
            sample_count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_p0 <= conv_word;
                    end else begin
                        skid_p1 <= conv_word;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_p0 <= skid_p1;
                    end
                    count <= count - 2'd1;
                end
                // Both at once only happens at count 1: the new word becomes the head.
                2'b11: head_p0 <= conv_word;
                default: ;
            endcase
            if (pop) begin
                sample_count <= sample_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sample_extend_pipe.sv
// Directed bench for sample_extend_pipe: scoreboard on the 16->32 instance, direct
// checks on the 12->24 and 16->16 instances.
module tb_sample_extend_pipe;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sample_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(4))  a_if ();
    sample_extend_pipe_if #(.IN_WIDTH(12), .OUT_WIDTH(24), .CNT_WIDTH(16)) b_if ();
    sample_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(16)) c_if ();

    sample_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave));
    sample_extend_pipe #(.IN_WIDTH(12), .OUT_WIDTH(24), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave));
    sample_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(16)) dut_c (
        .clk(clk), .reset(reset), .bus(c_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q[$];
    logic [3:0]  scnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        case (m)
            2'd0:    return {16'h0000, d};
            2'd1:    return {{16{d[15]}}, d};
            2'd2:    return {{17{~d[15]}}, d[14:0]};
            default: return {d, 16'h0000};
        endcase
    endfunction

    // One clock on instance A: score the handshakes visible before the edge, then advance.
    task automatic step_a(output bit acc);
        logic [31:0] exp;
        acc = 1'b0;
        if (reset) begin
            q.delete();
            scnt = 4'd0;
        end else begin
            if (a_if.out_valid && a_if.out_ready) begin
                if (q.size() == 0) begin
                    chk("stale_output", 32'(a_if.out_valid), 32'd0);
                end else begin
                    exp = q.pop_front();
                    chk("fifo_data", a_if.out_data, exp);
                end
                scnt = scnt + 4'd1;
            end
            if (a_if.in_valid && a_if.in_ready) begin
                q.push_back(model(a_if.in_data, a_if.in_mode));
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("sample_count", 32'(a_if.sample_count), 32'(scnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          acc;
        int          n;
        logic [3:0]  base;
        logic [31:0] sweep_exp [5];
        logic [15:0] sweep_in  [5];
        logic [1:0]  sweep_md  [5];

        checks = 0;
        errors = 0;
        scnt   = 4'd0;
        sweep_exp = '{32'h00008001, 32'hFFFF8001, 32'h00000001, 32'h80010000, 32'hFFFF8000};
        sweep_in  = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h0000};
        sweep_md  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};

        reset = 1'b1;
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_mode = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_mode = '0; b_if.out_ready = 1'b0;
        c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.in_mode = '0; c_if.out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Reset state
        chk("rst_in_ready", 32'(a_if.in_ready), 32'd0);
        chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_out_data", a_if.out_data, 32'd0);
        chk("rst_sample_count", 32'(a_if.sample_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(a_if.in_ready), 32'd1);

        // Mode sweep with out_ready held high
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = sweep_in[i];
            a_if.in_mode  = sweep_md[i];
            step_a(acc);
            chk("sweep_accept", 32'(acc), 32'd1);
            chk("sweep_valid", 32'(a_if.out_valid), 32'd1);
            chk("sweep_data", a_if.out_data, sweep_exp[i]);
        end
        a_if.in_valid = 1'b0;
        step_a(acc);
        chk("sweep_drained", 32'(a_if.out_valid), 32'd0);

        // Back-pressure: A and B fill the buffer, C waits
        base = scnt;
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1; a_if.in_mode = 2'd0;
        a_if.in_data = 16'h1111; step_a(acc); chk("bp_accept_a", 32'(acc), 32'd1);
        a_if.in_data = 16'h2222; step_a(acc); chk("bp_accept_b", 32'(acc), 32'd1);
        a_if.in_data = 16'h3333;
        chk("bp_full_ready", 32'(a_if.in_ready), 32'd0);
        step_a(acc); chk("bp_hold_c", 32'(acc), 32'd0);
        chk("bp_full_ready2", 32'(a_if.in_ready), 32'd0);
        chk("bp_head_a", a_if.out_data, 32'h00001111);
        a_if.out_ready = 1'b1;
        n = 0;
        while ((a_if.in_valid || a_if.out_valid) && n < 20) begin
            step_a(acc);
            if (acc) a_if.in_valid = 1'b0;
            n++;
        end
        chk("bp_drained", 32'(a_if.out_valid), 32'd0);
        chk("bp_all_emitted", 32'(q.size()), 32'd0);
        chk("bp_count_delta", 32'(a_if.sample_count - base), 32'd3);

        // Simultaneous push and pop at count 1
        a_if.in_valid = 1'b1; a_if.in_mode = 2'd0; a_if.in_data = 16'h0005;
        step_a(acc);
        chk("sim_head5", a_if.out_data, 32'h00000005);
        a_if.in_data = 16'h0006;
        chk("sim_ready", 32'(a_if.in_ready), 32'd1);
        step_a(acc);
        chk("sim_accept", 32'(acc), 32'd1);
        chk("sim_head6", a_if.out_data, 32'h00000006);
        chk("sim_valid", 32'(a_if.out_valid), 32'd1);
        chk("sim_count1_ready", 32'(a_if.in_ready), 32'd1);
        a_if.in_valid = 1'b0;
        step_a(acc);
        chk("sim_empty", 32'(a_if.out_valid), 32'd0);
        chk("sim_data_retained", a_if.out_data, 32'h00000006);

        // Reset with two samples buffered and a sample offered
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_data = 16'hAAAA; step_a(acc);
        a_if.in_data = 16'hBBBB; step_a(acc);
        a_if.in_data = 16'hCCCC;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(a_if.in_ready), 32'd0);
        step_a(acc);
        reset = 1'b0;
        a_if.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("midrst_out_data", a_if.out_data, 32'd0);
        chk("midrst_count", 32'(a_if.sample_count), 32'd0);
        chk("midrst_ready_after", 32'(a_if.in_ready), 32'd1);
        a_if.out_ready = 1'b1;
        repeat (3) step_a(acc);
        chk("midrst_no_stale", 32'(a_if.out_valid), 32'd0);

        // Counter wrap: 17 deliveries on a 4-bit counter
        a_if.in_valid = 1'b1; a_if.in_mode = 2'd1;
        for (int i = 0; i < 17; i++) begin
            a_if.in_data = 16'(i * 16'h0F0F);
            step_a(acc);
        end
        a_if.in_valid = 1'b0;
        step_a(acc);
        chk("wrap_count", 32'(a_if.sample_count), 32'd1);

        // Odd widths and IN = OUT
        b_if.out_ready = 1'b1; c_if.out_ready = 1'b1;
        b_if.in_valid = 1'b1; b_if.in_mode = 2'd1; b_if.in_data = 12'h800;
        c_if.in_valid = 1'b1; c_if.in_mode = 2'd2; c_if.in_data = 16'h8000;
        @(posedge clk); #1;
        chk("odd_valid", 32'(b_if.out_valid), 32'd1);
        chk("odd_sign_neg", 32'(b_if.out_data), 32'h00FFF800);
        chk("eq_valid", 32'(c_if.out_valid), 32'd1);
        chk("eq_offset", 32'(c_if.out_data), 32'h00000000);
        b_if.in_data = 12'h7FF;
        c_if.in_mode = 2'd1; c_if.in_data = 16'h8001;
        @(posedge clk); #1;
        chk("odd_sign_pos", 32'(b_if.out_data), 32'h000007FF);
        chk("eq_sign_pass", 32'(c_if.out_data), 32'h00008001);
        c_if.in_mode = 2'd3; c_if.in_data = 16'h1234;
        @(posedge clk); #1;
        chk("eq_ljust_pass", 32'(c_if.out_data), 32'h00001234);
        b_if.in_valid = 1'b0; c_if.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("eq_count", 32'(c_if.sample_count), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
